// File: rtl/nap_scheduler.sv
// nap_scheduler: nap countdown with ring, snooze and cancel handling, driving alarm start/stop pulses.
module nap_scheduler #(
    parameter int CYC_PER_MIN = 60,
    parameter int MAX_SNOOZE  = 3,
    parameter int RING_MIN    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic       cancel,
    input  logic [5:0] nap_min,
    input  logic [3:0] snooze_min,
    input  logic       user_stop,
    input  logic       snooze_btn,
    output logic       alarm_start,
    output logic       alarm_stop,
    output logic [2:0] state_out,
    output logic [5:0] remaining,
    output logic [1:0] snooze_cnt,
    output logic       done
);
    localparam int RT = RING_MIN * CYC_PER_MIN;
    localparam int PW = $clog2(CYC_PER_MIN);
    localparam int RW = $clog2(RT);
    localparam logic [PW-1:0] P_MAX = PW'(CYC_PER_MIN - 1);
    localparam logic [RW-1:0] R_MAX = RW'(RT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NAP    = 3'd1,
        RING   = 3'd2,
        SNOOZE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t          state;
    logic [PW-1:0]   prescaler;
    logic [RW-1:0]   ring_timer;

    assign state_out = state;

    // Scheduler FSM; every output is a register, pulses default low each cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prescaler   <= '0;
            ring_timer  <= '0;
            remaining   <= '0;
            snooze_cnt  <= '0;
            done        <= 1'b0;
            alarm_start <= 1'b0;
            alarm_stop  <= 1'b0;
        end else begin
            alarm_start <= 1'b0;
            alarm_stop  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (cancel) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end else if (go && nap_min != 6'd0) begin
                        state      <= NAP;
                        remaining  <= nap_min;
                        prescaler  <= '0;
                        snooze_cnt <= '0;
                        done       <= 1'b0;
                    end
                end
                NAP, SNOOZE: begin
                    if (cancel) begin
                        state      <= IDLE;
                        remaining  <= '0;
                        snooze_cnt <= '0;
                        alarm_stop <= 1'b1;
                    end else if (prescaler == P_MAX) begin
                        prescaler <= '0;
                        if (remaining == 6'd1) begin
                            state       <= RING;
                            remaining   <= '0;
                            ring_timer  <= '0;
                            alarm_start <= 1'b1;
                        end else begin
                            remaining <= remaining - 6'd1;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                RING: begin
                    if (cancel) begin
                        state      <= IDLE;
                        remaining  <= '0;
                        snooze_cnt <= '0;
                        alarm_stop <= 1'b1;
                    end else if (user_stop) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        alarm_stop <= 1'b1;
                    end else if (snooze_btn && snooze_cnt < 2'(MAX_SNOOZE) && snooze_min != 4'd0) begin
                        state      <= SNOOZE;
                        alarm_stop <= 1'b1;
                        snooze_cnt <= snooze_cnt + 2'd1;
                        remaining  <= {2'b00, snooze_min};
                        prescaler  <= '0;
                    end else if (ring_timer == R_MAX) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        alarm_stop <= 1'b1;
                    end else begin
                        ring_timer <= ring_timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nap_scheduler.sv
// tb_nap_scheduler: directed checks of nap_scheduler with CYC_PER_MIN=4, MAX_SNOOZE=3, RING_MIN=2.
module tb_nap_scheduler;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       go = 1'b0;
    logic       cancel = 1'b0;
    logic [5:0] nap_min = 6'd0;
    logic [3:0] snooze_min = 4'd0;
    logic       user_stop = 1'b0;
    logic       snooze_btn = 1'b0;
    logic       alarm_start;
    logic       alarm_stop;
    logic [2:0] state_out;
    logic [5:0] remaining;
    logic [1:0] snooze_cnt;
    logic       done;
    int         errors = 0;
    int         checks = 0;

    nap_scheduler #(.CYC_PER_MIN(4), .MAX_SNOOZE(3), .RING_MIN(2)) dut (
        .clock(clock),
        .reset(reset),
        .go(go),
        .cancel(cancel),
        .nap_min(nap_min),
        .snooze_min(snooze_min),
        .user_stop(user_stop),
        .snooze_btn(snooze_btn),
        .alarm_start(alarm_start),
        .alarm_stop(alarm_stop),
        .state_out(state_out),
        .remaining(remaining),
        .snooze_cnt(snooze_cnt),
        .done(done)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // asynchronous reset, checked before any clock edge
        #2 reset = 1'b1;
        #1 chk("reset_all", {alarm_start, alarm_stop, done, state_out, remaining, snooze_cnt}, 32'd0);
        tick;
        tick;
        reset = 1'b0;
        tick;
        chk("idle_after_reset", state_out, 3'd0);

        // basic nap of 2 minutes
        nap_min = 6'd2;
        go = 1'b1;
        tick;
        go = 1'b0;
        nap_min = 6'd9;
        chk("nap_enter_state", state_out, 3'd1);
        chk("nap_enter_rem", remaining, 6'd2);
        chk("nap_enter_cnt", snooze_cnt, 2'd0);
        for (int i = 1; i <= 8; i++) begin
            tick;
            if (i == 3) chk("nap_rem_c3", remaining, 6'd2);
            if (i == 4) chk("nap_rem_c4", remaining, 6'd1);
            if (i == 7) chk("nap_no_start_c7", {alarm_start, state_out}, {1'b0, 3'd1});
            if (i == 8) chk("nap_ring_c8", {alarm_start, alarm_stop, state_out, remaining}, {1'b1, 1'b0, 3'd2, 6'd0});
        end
        tick;
        chk("start_one_cycle", {alarm_start, state_out}, {1'b0, 3'd2});

        // user stop while ringing
        user_stop = 1'b1;
        tick;
        user_stop = 1'b0;
        chk("stop_pulse", {alarm_stop, alarm_start, state_out, done}, {1'b1, 1'b0, 3'd4, 1'b1});
        tick;
        chk("stop_pulse_end", {alarm_stop, state_out, done}, {1'b0, 3'd4, 1'b1});

        // snooze exhaustion from DONE
        nap_min = 6'd1;
        snooze_min = 4'd1;
        go = 1'b1;
        tick;
        go = 1'b0;
        chk("ex_nap", {state_out, remaining, done}, {3'd1, 6'd1, 1'b0});
        repeat (4) tick;
        chk("ex_ring0", {alarm_start, state_out}, {1'b1, 3'd2});
        for (int k = 1; k <= 3; k++) begin
            snooze_btn = 1'b1;
            tick;
            snooze_btn = 1'b0;
            chk("ex_snooze", {alarm_stop, state_out, snooze_cnt, remaining}, {1'b1, 3'd3, 2'(k), 6'd1});
            repeat (3) tick;
            chk("ex_no_start_early", {alarm_start, state_out}, {1'b0, 3'd3});
            tick;
            chk("ex_restart", {alarm_start, state_out}, {1'b1, 3'd2});
        end
        snooze_btn = 1'b1;
        tick;
        snooze_btn = 1'b0;
        chk("ex_fourth_ignored", {alarm_stop, state_out, snooze_cnt}, {1'b0, 3'd2, 2'd3});
        repeat (6) tick;
        chk("ex_still_ring_r7", {alarm_stop, state_out}, {1'b0, 3'd2});
        tick;
        chk("ex_timeout_r8", {alarm_stop, state_out, done, snooze_cnt}, {1'b1, 3'd4, 1'b1, 2'd3});

        // user_stop and snooze_btn together in RING
        go = 1'b1;
        tick;
        go = 1'b0;
        repeat (4) tick;
        snooze_btn = 1'b1;
        tick;
        snooze_btn = 1'b0;
        chk("sim_snooze1", {state_out, snooze_cnt}, {3'd3, 2'd1});
        repeat (4) tick;
        chk("sim_ring", state_out, 3'd2);
        user_stop = 1'b1;
        snooze_btn = 1'b1;
        tick;
        user_stop = 1'b0;
        snooze_btn = 1'b0;
        chk("sim_stop_wins", {alarm_stop, state_out, snooze_cnt, done}, {1'b1, 3'd4, 2'd1, 1'b1});

        // cancel beats go in DONE and IDLE
        cancel = 1'b1;
        go = 1'b1;
        nap_min = 6'd3;
        tick;
        chk("cancel_done", {alarm_stop, state_out, done}, {1'b0, 3'd0, 1'b0});
        tick;
        cancel = 1'b0;
        go = 1'b0;
        chk("cancel_go_idle", {alarm_stop, state_out, remaining}, {1'b0, 3'd0, 6'd0});

        // cancel mid-NAP at cycle 6
        nap_min = 6'd5;
        go = 1'b1;
        tick;
        go = 1'b0;
        repeat (5) tick;
        chk("cnap_before", {state_out, remaining}, {3'd1, 6'd4});
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        chk("cnap_cancel", {alarm_stop, state_out, remaining, snooze_cnt}, {1'b1, 3'd0, 6'd0, 2'd0});
        tick;
        chk("cnap_pulse_end", alarm_stop, 1'b0);
        nap_min = 6'd0;
        go = 1'b1;
        tick;
        go = 1'b0;
        chk("go_zero_ignored", {state_out, remaining}, {3'd0, 6'd0});

        // reset asserted mid-RING
        nap_min = 6'd1;
        go = 1'b1;
        tick;
        go = 1'b0;
        repeat (6) tick;
        chk("rr_ringing", state_out, 3'd2);
        #2 reset = 1'b1;
        #1 chk("rr_async", {alarm_start, alarm_stop, done, state_out, remaining, snooze_cnt}, 32'd0);
        tick;
        chk("rr_no_stop", {alarm_stop, state_out}, {1'b0, 3'd0});
        reset = 1'b0;
        tick;
        chk("rr_idle", {alarm_stop, alarm_start, state_out}, {1'b0, 1'b0, 3'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nap_scheduler.md
NAP_SCHEDULER -- requirements
Module: nap_scheduler

Interface
REQ-001 Parameter CYC_PER_MIN, default 60: clock cycles per nap minute, must be ≥2.
REQ-002 Parameter MAX_SNOOZE, default 3: maximum snoozes per nap, range 0..3.
REQ-003 Parameter RING_MIN, default 2: ring duration in minutes before auto-stop, must be ≥1.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 go  input  1  start nap; level-sampled each edge.
REQ-007 cancel  input  1  abort the nap from any state.
REQ-008 nap_min  input  6  nap length in minutes; sampled only when go is accepted.
REQ-009 snooze_min  input  4  snooze length in minutes; sampled only when a snooze is accepted.
REQ-010 user_stop  input  1  user acknowledges the alarm.
REQ-011 snooze_btn  input  1  user requests a snooze.
REQ-012 alarm_start  output  1  one-cycle pulse to the alarm pattern generator's start input.
REQ-013 alarm_stop  output  1  one-cycle pulse to the alarm pattern generator's stop input.
REQ-014 state_out  output  3  current state code.
REQ-015 remaining  output  6  whole minutes left in the current NAP/SNOOZE countdown.
REQ-016 snooze_cnt  output  2  snoozes used in the current nap.
REQ-017 done  output  1  high while in DONE.

Function
REQ-018 State codes: IDLE=0, NAP=1, RING=2, SNOOZE=3, DONE=4; codes 5..7 return to IDLE on the next edge with no output pulse.
REQ-019 All outputs are registered; alarm_start and alarm_stop are never high in the same cycle.
REQ-020 IDLE or DONE, go=1 and nap_min≠0:
- go to NAP;
- remaining←nap_min; prescaler←0; snooze_cnt←0; done←0.
REQ-021 IDLE or DONE, go=1 and nap_min=0: no state change.
REQ-022 Prescaler behaviour in NAP/SNOOZE:
- counts 0..CYC_PER_MIN-1 and wraps;
- on each wrap, remaining decrements by 1.
REQ-023 On the wrap where remaining=1:
- go to RING; remaining←0;
- alarm_start=1 for exactly the following cycle.
- Countdown is therefore exactly minutes×CYC_PER_MIN cycles from entry.
REQ-024 RING: the ring timer counts up to RING_MIN×CYC_PER_MIN cycles; remaining holds 0.
REQ-025 RING input priority, highest first: cancel, user_stop, snooze_btn, ring timeout.
REQ-026 RING, user_stop=1, or ring timer expired: go to DONE; alarm_stop pulse one cycle.
REQ-027 RING, snooze_btn=1, snooze_cnt<MAX_SNOOZE and snooze_min≠0:
- go to SNOOZE; alarm_stop pulse;
- snooze_cnt increments; remaining←snooze_min; prescaler←0.
REQ-028 RING, snooze_btn=1 with snooze_cnt=MAX_SNOOZE or snooze_min=0: ignored; RING continues and the ring timer is not reset.
REQ-029 cancel=1 in NAP, SNOOZE or RING:
- go to IDLE; remaining←0; snooze_cnt←0;
- alarm_stop pulse one cycle, even if not ringing.
REQ-030 cancel=1 in IDLE or DONE: go to IDLE with no pulse; cancel beats go in the same cycle.
REQ-031 go, user_stop and snooze_btn are ignored in NAP and SNOOZE; nap_min and snooze_min changes mid-countdown have no effect.
REQ-032 done=1 exactly when state_out=4.

Reset
REQ-033 While reset=1, asynchronously:
- state IDLE; prescaler and ring timer 0;
- remaining=0, snooze_cnt=0, done=0, alarm_start=0, alarm_stop=0, state_out=0.
REQ-034 Reset asserted mid-RING clears everything without issuing alarm_stop; the alarm generator shares the same reset.

Verification
All scenarios use CYC_PER_MIN=4, MAX_SNOOZE=3, RING_MIN=2.
REQ-035 Basic nap: nap_min=2, go for one cycle -> alarm_start high exactly 8 cycles after the go edge; remaining steps 2,1,0 at 4-cycle intervals.
REQ-036 Stop: in RING, user_stop for one cycle -> alarm_stop pulse, then state_out=4 and done=1.
REQ-037 Snooze exhaustion: snooze_min=1; snooze three times -> three alarm_start pulses 4 cycles after each snooze; snooze_cnt ends at 3; a fourth snooze_btn is ignored; DONE with alarm_stop 8 cycles after that ring began.
REQ-038 Simultaneous inputs:
- user_stop and snooze_btn in the same RING cycle -> DONE, snooze_cnt unchanged.
- cancel and go in IDLE -> stays IDLE.
REQ-039 Cancel mid-NAP: nap_min=5, cancel at cycle 6 -> alarm_stop pulse, IDLE, remaining=0; go with nap_min=0 -> stays IDLE.
REQ-040 Reset mid-RING: reset asserted -> all outputs 0 immediately (asynchronous), no alarm_stop pulse, state_out=0.
